// File: rtl/aiv_sync_locked_tracker.sv
// Video sync tracker: flywheel dot/line counters, hsync quality judging, lock FSM,
// and a registered active-region index generator.
module aiv_sync_locked_tracker #(
  parameter int H_TOTAL    = 864,
  parameter int V_TOTAL    = 312,
  parameter int H_START    = 72,
  parameter int H_ACTIVE   = 720,
  parameter int V_START    = 23,
  parameter int V_ACTIVE   = 288,
  parameter int INTERLACED = 1,
  parameter int TICK_PHASE = 0,
  parameter int H_TOL      = 2,
  parameter int LOCK_LINES = 8,
  parameter int MISS_LIMIT = 4,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic [2:0]    clkPhase,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          isFieldOdd,
  output logic [CW-1:0] active_frame_dot,
  output logic [CW-1:0] active_frame_line,
  output logic          display_enable,
  output logic          frame_start_flag,
  output logic          line_start_flag,
  output logic          locked,
  output logic [7:0]    sync_err_count
);

  // state    | meaning
  // S_SEARCH | no phase reference; waiting for any hsync edge
  // S_VERIFY | counting consecutive good lines toward lock
  // S_LOCKED | outputs enabled; counting consecutive bad lines
  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam int GW = (LOCK_LINES < 1) ? 1 : $clog2(LOCK_LINES + 1);
  localparam int MW = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

  state_t        r_state;
  logic          r_locked;
  logic [GW-1:0] r_good_cnt;
  logic [MW-1:0] r_miss_cnt;
  logic [7:0]    r_err_cnt;

  logic          r_hs_cur, r_hs_prev, r_vs_cur, r_vs_prev;
  logic          r_hs_pend, r_vs_pend;
  logic [CW-1:0] r_dot, r_line;
  logic          r_fly_pend;

  logic [CW-1:0] r_afd, r_afl;
  logic          r_de, r_fsf, r_lsf;

  logic          w_tick;
  logic          w_hs_edge, w_vs_edge, w_hs_evt, w_vs_evt;
  logic          w_dot_last, w_early, w_late, w_wrap;
  logic          w_hs_good, w_hs_bad, w_fly_bad;
  logic          w_line_adv, w_judge, w_good_line, w_bad_line;
  logic [CW:0]   w_dot_x, w_line_x;
  logic          w_h_act, w_v_act, w_active;
  logic [CW-1:0] w_afd, w_vrel, w_afl;

  assign w_tick    = (clkPhase == 3'(TICK_PHASE));
  assign w_hs_edge = r_hs_cur & ~r_hs_prev;
  assign w_vs_edge = r_vs_cur & ~r_vs_prev;
  assign w_hs_evt  = r_hs_pend | w_hs_edge;
  assign w_vs_evt  = r_vs_pend | w_vs_edge;

  assign w_dot_last = (r_dot == CW'(H_TOTAL - 1));
  assign w_early    = (r_dot >= CW'(H_TOTAL - 1 - H_TOL));
  // An edge shortly after a flywheel wrap is a late edge of the line just closed.
  assign w_late     = r_fly_pend && (r_dot < CW'(H_TOL));
  assign w_wrap     = !w_hs_evt && w_dot_last;
  assign w_hs_good  = w_hs_evt && (w_early || w_late);
  assign w_hs_bad   = w_hs_evt && !(w_early || w_late);
  assign w_fly_bad  = !w_hs_evt && r_fly_pend && (r_dot == CW'(H_TOL - 1));
  // The wrap already advanced the line, so a late edge only re-phases the dot.
  assign w_line_adv = (w_hs_evt && !w_late) || w_wrap;

  assign w_judge     = w_tick && (r_state != S_SEARCH);
  assign w_good_line = w_judge && w_hs_good;
  assign w_bad_line  = w_judge && (w_hs_bad || w_fly_bad);

  assign w_dot_x  = {1'b0, r_dot};
  assign w_line_x = {1'b0, r_line};
  assign w_h_act  = (w_dot_x >= (CW+1)'(H_START)) &&
                    (w_dot_x < (CW+1)'(H_START + H_ACTIVE));
  assign w_v_act  = (w_line_x >= (CW+1)'(V_START)) &&
                    (w_line_x < (CW+1)'(V_START + V_ACTIVE));
  assign w_active = w_h_act && w_v_act;

  assign w_afd  = r_dot - CW'(H_START);
  assign w_vrel = r_line - CW'(V_START);
  assign w_afl  = (INTERLACED != 0) ? {w_vrel[CW-2:0], isFieldOdd} : w_vrel;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_hs_cur  <= 1'b0;
      r_hs_prev <= 1'b0;
      r_vs_cur  <= 1'b0;
      r_vs_prev <= 1'b0;
      r_hs_pend <= 1'b0;
      r_vs_pend <= 1'b0;
    end else begin
      r_hs_cur  <= hsync;
      r_hs_prev <= r_hs_cur;
      r_vs_cur  <= vsync;
      r_vs_prev <= r_vs_cur;
      if (w_tick)         r_hs_pend <= 1'b0;
      else if (w_hs_edge) r_hs_pend <= 1'b1;
      if (w_tick)         r_vs_pend <= 1'b0;
      else if (w_vs_edge) r_vs_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_dot      <= '0;
      r_line     <= '0;
      r_fly_pend <= 1'b0;
    end else if (w_tick) begin
      if (w_hs_evt || w_dot_last) r_dot <= '0;
      else                        r_dot <= r_dot + 1'b1;

      if (w_vs_evt)
        r_line <= '0;
      else if (w_line_adv)
        r_line <= (r_line == CW'(V_TOTAL - 1)) ? '0 : r_line + 1'b1;

      if (w_hs_evt)       r_fly_pend <= 1'b0;
      else if (w_wrap)    r_fly_pend <= 1'b1;
      else if (w_fly_bad) r_fly_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state    <= S_SEARCH;
      r_locked   <= 1'b0;
      r_good_cnt <= '0;
      r_miss_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_bad_line && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 1'b1;

      case (r_state)
        S_SEARCH: begin
          if (w_tick && w_hs_evt) begin
            r_state    <= S_VERIFY;
            r_good_cnt <= '0;
          end
        end
        S_VERIFY: begin
          if (w_bad_line) begin
            r_state <= S_SEARCH;
          end else if (w_good_line) begin
            r_good_cnt <= r_good_cnt + 1'b1;
            if (r_good_cnt == GW'(LOCK_LINES - 1)) begin
              r_state    <= S_LOCKED;
              r_locked   <= 1'b1;
              r_miss_cnt <= '0;
            end
          end
        end
        S_LOCKED: begin
          if (w_bad_line) begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
            if (r_miss_cnt == MW'(MISS_LIMIT - 1)) begin
              r_state  <= S_SEARCH;
              r_locked <= 1'b0;
            end
          end else if (w_good_line) begin
            r_miss_cnt <= '0;
          end
        end
        default: begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Outputs sample the pre-tick counters and lock state, giving one tick of latency.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_de  <= 1'b0;
      r_afd <= '0;
      r_afl <= '0;
      r_lsf <= 1'b0;
      r_fsf <= 1'b0;
    end else if (w_tick) begin
      if (r_locked && w_active) begin
        r_de  <= 1'b1;
        r_afd <= w_afd;
        r_afl <= w_afl;
        r_lsf <= (w_afd == '0);
        r_fsf <= (w_afd == '0) && (w_vrel == '0) && (isFieldOdd || (INTERLACED == 0));
      end else begin
        r_de  <= 1'b0;
        r_afd <= '0;
        r_afl <= '0;
        r_lsf <= 1'b0;
        r_fsf <= 1'b0;
      end
    end
  end

  assign active_frame_dot  = r_afd;
  assign active_frame_line = r_afl;
  assign display_enable    = r_de;
  assign frame_start_flag  = r_fsf;
  assign line_start_flag   = r_lsf;
  assign locked            = r_locked;
  assign sync_err_count    = r_err_cnt;

endmodule

// File: tb/tb_aiv_sync_locked_tracker.sv
// Directed bench for aiv_sync_locked_tracker using a scaled raster (40 dots x 20 lines),
// one dot per 8 clocks with clkPhase cycling 0..7.
module tb_aiv_sync_locked_tracker;
  localparam int HT = 40, VT = 20, HS = 6, HA = 24, VS = 3, VA = 12, CW = 10;
  localparam int FIELD = HT * VT;

  logic          clk = 1'b0;
  logic          nReset;
  logic [2:0]    clkPhase;
  logic          hsync, vsync, isFieldOdd;
  logic [CW-1:0] active_frame_dot, active_frame_line;
  logic          display_enable, frame_start_flag, line_start_flag, locked;
  logic [7:0]    sync_err_count;

  int n_chk  = 0;
  int n_pass = 0;
  int g_next = 0;

  always #5 clk = ~clk;

  aiv_sync_locked_tracker #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACTIVE(HA), .V_START(VS),
    .V_ACTIVE(VA), .INTERLACED(1), .TICK_PHASE(0), .H_TOL(2), .LOCK_LINES(8),
    .MISS_LIMIT(4), .CW(CW)
  ) dut (
    .clk(clk), .nReset(nReset), .clkPhase(clkPhase), .hsync(hsync), .vsync(vsync),
    .isFieldOdd(isFieldOdd), .active_frame_dot(active_frame_dot),
    .active_frame_line(active_frame_line), .display_enable(display_enable),
    .frame_start_flag(frame_start_flag), .line_start_flag(line_start_flag),
    .locked(locked), .sync_err_count(sync_err_count)
  );

  function automatic int gs(input int f, input int l, input int s);
    return f * FIELD + l * HT + s;
  endfunction

  // Source hsync: one-dot pulse at dot 0, with a 3-line dropout, an off-period
  // burst (period 21 dots), a silent gap, and a 10-dot-wide pulse.
  function automatic logic gen_hs(input int g);
    int f, l, s;
    f = g / FIELD; l = (g / HT) % VT; s = g % HT;
    if (g >= 2761 && g <= 2845) return ((g - 2761) % 21) == 20;
    if (g > 2845 && g < 3200)   return 1'b0;
    if (f == 2 && l >= 5 && l <= 7) return 1'b0;
    if (f == 4 && l == 9) return s < 10;
    return s == 0;
  endfunction

  function automatic logic gen_vs(input int g);
    return ((g < 2761) || (g >= 3200)) && ((g % FIELD) == 0);
  endfunction

  task automatic gen_step();
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      clkPhase = 3'(p);
      if (p == 0) begin
        hsync      = gen_hs(g_next);
        vsync      = gen_vs(g_next);
        isFieldOdd = ((g_next / FIELD) % 2) == 1;
      end
    end
    g_next++;
  endtask

  task automatic run_to(input int g);
    while (g_next <= g) gen_step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_de"},   32'(display_enable), 0);
    chk({tag, "_afd"},  32'(active_frame_dot), 0);
    chk({tag, "_afl"},  32'(active_frame_line), 0);
    chk({tag, "_lsf"},  32'(line_start_flag), 0);
    chk({tag, "_fsf"},  32'(frame_start_flag), 0);
    chk({tag, "_lock"}, 32'(locked), 0);
    chk({tag, "_err"},  32'(sync_err_count), 0);
  endtask

  initial begin
    nReset = 1'b0; hsync = 1'b0; vsync = 1'b0; isFieldOdd = 1'b0; clkPhase = 3'd0;
    repeat (12) begin
      @(negedge clk);
      clkPhase = clkPhase + 3'd1;
    end
    chk_all_zero("reset");
    @(negedge clk);
    nReset = 1'b1;

    // Acquisition: first edge enters VERIFY, eight good lines lock
    run_to(gs(0, 8, 0));  chk("lock_pre", 32'(locked), 0);
    run_to(gs(0, 8, 1));  chk("lock_at8", 32'(locked), 1);
    run_to(gs(0, 8, 7));  chk("h_before", 32'(display_enable), 0);
    run_to(gs(0, 8, 8));
    chk("l8_de", 32'(display_enable), 1);
    chk("l8_afd", 32'(active_frame_dot), 0);
    chk("l8_afl", 32'(active_frame_line), 10);
    chk("l8_lsf", 32'(line_start_flag), 1);
    chk("l8_fsf", 32'(frame_start_flag), 0);
    run_to(gs(0, 8, 9));
    chk("lsf_once", 32'(line_start_flag), 0);
    chk("afd_1", 32'(active_frame_dot), 1);
    run_to(gs(0, 8, 31)); chk("afd_last", 32'(active_frame_dot), 23);
    chk("de_last", 32'(display_enable), 1);
    run_to(gs(0, 8, 32)); chk("h_after_de", 32'(display_enable), 0);
    chk("h_after_afd", 32'(active_frame_dot), 0);
    run_to(gs(0, 14, 8)); chk("v_last_afl", 32'(active_frame_line), 22);
    run_to(gs(0, 15, 8)); chk("v_after_de", 32'(display_enable), 0);

    // Odd field: first active pixel marks the frame start
    run_to(gs(1, 2, 8));  chk("v_before_de", 32'(display_enable), 0);
    run_to(gs(1, 3, 8));
    chk("odd_fsf", 32'(frame_start_flag), 1);
    chk("odd_afd", 32'(active_frame_dot), 0);
    chk("odd_afl", 32'(active_frame_line), 1);
    chk("odd_lsf", 32'(line_start_flag), 1);
    chk("odd_de", 32'(display_enable), 1);
    run_to(gs(1, 3, 9));  chk("fsf_once", 32'(frame_start_flag), 0);
    run_to(gs(1, 4, 8));  chk("odd_afl4", 32'(active_frame_line), 3);
    chk("odd_fsf4", 32'(frame_start_flag), 0);

    // Even field start of active area
    run_to(gs(2, 3, 8));
    chk("even_afl", 32'(active_frame_line), 0);
    chk("even_afd", 32'(active_frame_dot), 0);
    chk("even_lsf", 32'(line_start_flag), 1);
    chk("even_fsf", 32'(frame_start_flag), 0);

    // hsync dropped for lines 5..7: flywheel keeps phase, three misses
    run_to(gs(2, 6, 8));
    chk("fly_afl", 32'(active_frame_line), 6);
    chk("fly_afd", 32'(active_frame_dot), 0);
    chk("fly_de", 32'(display_enable), 1);
    run_to(gs(2, 7, 39));
    chk("fly_lock", 32'(locked), 1);
    chk("fly_err", 32'(sync_err_count), 3);
    run_to(gs(2, 8, 8));
    chk("fly_afl8", 32'(active_frame_line), 10);
    chk("fly_lock8", 32'(locked), 1);

    // Reset in the middle of an active line
    run_to(gs(2, 10, 15));
    chk("pre_rst_de", 32'(display_enable), 1);
    chk("pre_rst_afd", 32'(active_frame_dot), 7);
    nReset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    nReset = 1'b1;
    run_to(gs(2, 19, 0)); chk("relock_pre", 32'(locked), 0);
    run_to(gs(2, 19, 1)); chk("relock_at8", 32'(locked), 1);

    // Off-period hsync: edges at dot 20, four bad lines drop lock
    run_to(2824);
    chk("bad3_lock", 32'(locked), 1);
    chk("bad3_err", 32'(sync_err_count), 3);
    run_to(2845);
    chk("bad4_lock", 32'(locked), 0);
    chk("bad4_err", 32'(sync_err_count), 4);
    chk("bad4_de", 32'(display_enable), 1);
    run_to(2846); chk("unlock_de", 32'(display_enable), 0);
    run_to(2852); chk("unlock_de_act", 32'(display_enable), 0);

    // Simultaneous hsync+vsync edges restart at dot 0, line 0
    run_to(gs(4, 8, 8));
    chk("sim_lock", 32'(locked), 1);
    chk("sim_de", 32'(display_enable), 1);
    chk("sim_afd", 32'(active_frame_dot), 0);
    chk("sim_afl", 32'(active_frame_line), 10);
    chk("sim_err", 32'(sync_err_count), 4);

    // Wide hsync on line 9 must act as a single edge
    run_to(gs(4, 10, 8));
    chk("wide_lock", 32'(locked), 1);
    chk("wide_err", 32'(sync_err_count), 4);
    chk("wide_afl", 32'(active_frame_line), 14);
    chk("wide_afd", 32'(active_frame_dot), 0);
    chk("wide_lsf", 32'(line_start_flag), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
